// File: rtl/pe_cube_seq.sv
`default_nettype none
// ============================================================================
// Module   : pe_cube_seq
// Purpose  : Layer-job sequencer for the PE cube. Walks T output tiles; each
//            tile is one MAC phase of K*K feed cycles followed by DRAIN_CYC
//            idle cycles. Drives accumulator clear, per-row configuration and
//            the weight/data buffer read addresses.
// Ports    : iClk, iRstN (async, active low)
//            iStart, iKernelSize, iTileCount, iPatternSel, iPassDataLeft,
//            iOutputShift, iStall                        -> job/flow inputs
//            oBusy, oDone, oClearAcc, oFeedValid         -> status/strobes
//            oWeightAddr, oDataAddr, oTileIdx            -> buffer/tile info
//            oCfsInputPattern, oCfsPassDataLeft,
//            oCfsOutputLeftShift                         -> latched config
// Revision : 1.0 - initial release
// ============================================================================
module pe_cube_seq #(
  parameter int ARRAY_NUM = 3,
  parameter int ADDR_W    = 10,
  parameter int KSIZE_W   = 4,
  parameter int TILE_W    = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic                   iClk,
  input  logic                   iRstN,
  input  logic                   iStart,
  input  logic [KSIZE_W-1:0]     iKernelSize,
  input  logic [TILE_W-1:0]      iTileCount,
  input  logic [3*ARRAY_NUM-1:0] iPatternSel,
  input  logic [ARRAY_NUM-2:0]   iPassDataLeft,
  input  logic [4:0]             iOutputShift,
  input  logic                   iStall,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oClearAcc,
  output logic                   oFeedValid,
  output logic [ADDR_W-1:0]      oWeightAddr,
  output logic [ADDR_W-1:0]      oDataAddr,
  output logic [TILE_W-1:0]      oTileIdx,
  output logic [3*ARRAY_NUM-1:0] oCfsInputPattern,
  output logic [ARRAY_NUM-2:0]   oCfsPassDataLeft,
  output logic [4:0]             oCfsOutputLeftShift
);

  localparam int C_MAC_W = 2 * KSIZE_W;
  localparam int C_DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [C_DRN_W-1:0] C_DRAIN_LAST = C_DRN_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // r_state is the phase of the cycle currently presented on the outputs;
  // every output for the next cycle is decided at the edge that opens it.
  state_t               r_state;
  logic [C_MAC_W-1:0]   r_mac_cnt;    // index of the next feed in this tile
  logic [C_MAC_W-1:0]   r_ksq;        // latched K*K
  logic [ADDR_W-1:0]    r_data_cnt;   // next data buffer address
  logic [C_DRN_W-1:0]   r_drain_cnt;
  logic [TILE_W-1:0]    r_tlast;      // latched T-1

  state_t               w_state_nxt;
  logic                 w_issue;      // next cycle is a feed
  logic                 w_load;
  logic                 w_done_nxt;
  logic [C_MAC_W-1:0]   w_mac_base;   // feed index used if w_issue
  logic [ADDR_W-1:0]    w_data_base;
  logic [TILE_W-1:0]    w_tile_nxt;
  logic [C_DRN_W-1:0]   w_drain_nxt;
  logic [C_MAC_W-1:0]   w_kx;
  logic [C_MAC_W-1:0]   w_ksq;
  logic [ADDR_W-1:0]    w_waddr;

  // K=0 is treated as K=1.
  assign w_kx  = {{KSIZE_W{1'b0}}, (iKernelSize == '0) ? KSIZE_W'(1) : iKernelSize};
  assign w_ksq = w_kx * w_kx;

  assign w_data_base = w_load ? '0 : r_data_cnt;

  generate
    if (ADDR_W > C_MAC_W) begin : g_waddr_ext
      assign w_waddr = {{(ADDR_W - C_MAC_W){1'b0}}, w_mac_base};
    end else if (ADDR_W == C_MAC_W) begin : g_waddr_same
      assign w_waddr = w_mac_base;
    end else begin : g_waddr_trunc
      assign w_waddr = w_mac_base[ADDR_W-1:0];
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;
    w_mac_base  = r_mac_cnt;
    w_tile_nxt  = oTileIdx;
    w_drain_nxt = r_drain_cnt;
    case (r_state)
      S_IDLE: begin
        if (iStart) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_load     = 1'b1;
        w_tile_nxt = '0;
        w_mac_base = '0;
        if (iTileCount == '0) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_MAC;
          w_issue     = ~iStall;
        end
      end
      S_MAC: begin
        // Counter equal to K*K means the last feed was the cycle just shown.
        if (r_mac_cnt == r_ksq) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = '0;
        end else begin
          w_issue = ~iStall;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == C_DRAIN_LAST) begin
          if (oTileIdx == r_tlast) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_MAC;
            w_tile_nxt  = oTileIdx + 1'b1;
            w_mac_base  = '0;
            w_issue     = ~iStall;
          end
        end else begin
          w_drain_nxt = r_drain_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state             <= S_IDLE;
      r_mac_cnt           <= '0;
      r_ksq               <= '0;
      r_data_cnt          <= '0;
      r_drain_cnt         <= '0;
      r_tlast             <= '0;
      oBusy               <= 1'b0;
      oDone               <= 1'b0;
      oClearAcc           <= 1'b0;
      oFeedValid          <= 1'b0;
      oWeightAddr         <= '0;
      oDataAddr           <= '0;
      oTileIdx            <= '0;
      oCfsInputPattern    <= '0;
      oCfsPassDataLeft    <= '0;
      oCfsOutputLeftShift <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_mac_cnt   <= w_issue ? (w_mac_base + 1'b1) : w_mac_base;
      oBusy       <= (w_state_nxt != S_IDLE);
      oDone       <= w_done_nxt;
      oFeedValid  <= w_issue;
      oClearAcc   <= w_issue && (w_mac_base == '0);
      oTileIdx    <= w_tile_nxt;
      if (w_issue) begin
        oWeightAddr <= w_waddr;
        oDataAddr   <= w_data_base;
        r_data_cnt  <= w_data_base + 1'b1;  // wraps modulo 2^ADDR_W
      end else if (w_load) begin
        oWeightAddr <= '0;
        oDataAddr   <= '0;
        r_data_cnt  <= '0;
      end
      if (w_load) begin
        r_ksq               <= w_ksq;
        r_tlast             <= iTileCount - 1'b1;
        oCfsInputPattern    <= iPatternSel;
        oCfsPassDataLeft    <= iPassDataLeft;
        oCfsOutputLeftShift <= iOutputShift;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/pe_cube_seq.md
Name: pe_cube_seq

Overview:
Sequencer for the PE cube datapath. It accepts a layer job and walks the cube through output tiles. For each tile it runs one MAC phase of K*K feed cycles, then a drain phase. It drives the cube's accumulator clear, the per-row input-pattern, pass-left and output-shift configuration, and the weight/data buffer read addresses that feed the cube.

Parameters:
ARRAY_NUM, 3, PE rows per block; sets the pattern and pass-left widths.
ADDR_W, 10, width of the weight and data buffer read addresses.
KSIZE_W, 4, width of the kernel-size field.
TILE_W, 8, width of the tile-count and tile-index fields.
DRAIN_CYC, 4, idle cycles after each MAC phase. Covers the cube's 2-cycle clear delay plus result pipeline. Must be >= 1.

Ports:
iClk  in  1  clock; all state changes on its rising edge.
iRstN  in  1  asynchronous active-low reset.
iStart  in  1  job start pulse; accepted only in IDLE.
iKernelSize  in  KSIZE_W  K; the MAC phase length is K*K. K=0 is treated as K=1.
iTileCount  in  TILE_W  number of output tiles T.
iPatternSel  in  3*ARRAY_NUM  per-row input-pattern codes (0..4).
iPassDataLeft  in  ARRAY_NUM-1  pass-left enables.
iOutputShift  in  5  result left-shift amount.
iStall  in  1  buffers not ready; freezes the MAC phase.
oBusy  out  1  high from the LOAD state through the DONE state inclusive.
oDone  out  1  one-cycle pulse at job end.
oClearAcc  out  1  one-cycle pulse marking the first feed of each tile.
oFeedValid  out  1  buffers read / cube consumes this cycle.
oWeightAddr  out  ADDR_W  weight buffer read address.
oDataAddr  out  ADDR_W  data buffer read address.
oTileIdx  out  TILE_W  current tile index.
oCfsInputPattern  out  3*ARRAY_NUM  latched copy of iPatternSel.
oCfsPassDataLeft  out  ARRAY_NUM-1  latched copy of iPassDataLeft.
oCfsOutputLeftShift  out  5  latched copy of iOutputShift.

Behaviour:
- Reset (iRstN low, asynchronous): state goes to IDLE and every output and counter goes to 0 immediately. Asserting reset mid-job aborts the job with no oDone.
- All outputs are registered.
- States: IDLE, LOAD, MAC, DRAIN, DONE.
- IDLE:
  - iStart=1 -> LOAD.
  - iStart in any other state is ignored.
- LOAD (1 cycle):
  - Latch K (with 0 replaced by 1), T and all configuration inputs.
  - Configuration outputs update from this edge and hold until the next LOAD.
  - Zero the tile index, MAC counter, oWeightAddr and oDataAddr.
  - T=0 -> DONE; otherwise -> MAC.
- MAC:
  - The MAC counter runs 0..K*K-1 and is 2*KSIZE_W bits wide.
  - When iStall=0: oFeedValid=1, oWeightAddr = MAC counter, oDataAddr = running data count. Both counters advance afterwards.
  - When iStall=1: oFeedValid=0 and both counters hold. Stall has no effect in any other state.
  - oClearAcc=1 only on the first non-stalled MAC cycle of a tile, so it coincides with feed 0. Stalls before feed 0 delay the clear.
  - After the feed with counter = K*K-1 -> DRAIN.
- DRAIN:
  - Lasts DRAIN_CYC cycles with oFeedValid=0.
  - Then, if tile index = T-1 -> DONE.
  - Otherwise tile index +1, MAC counter cleared -> MAC.
- DONE (1 cycle): oDone=1, then -> IDLE.
- oWeightAddr restarts at 0 every tile.
- oDataAddr is continuous across tiles and wraps modulo 2^ADDR_W without error.
- No-stall latency from an iStart at cycle 0:
  - First feed (with clear) at cycle 2.
  - oDone at cycle 2 + T*(K*K + DRAIN_CYC).

Test Plan:
- Nominal job: K=3, T=2, DRAIN_CYC=4, no stall, start at cycle 0.
  - LOAD at cycle 1.
  - Feeds at cycles 2..10 and 15..23.
  - oClearAcc at cycles 2 and 15.
  - oWeightAddr 0..8 in each tile; oDataAddr 0..17.
  - oDone at cycle 28; oBusy high for cycles 1..28.
- Stall: same job with iStall=1 at cycles 2..3 and 6.
  - Clear and feed 0 move to cycle 4.
  - Tile-0 feeds at cycles 4,5,7..13; DRAIN 14..17.
  - oDone at cycle 31; address sequence unchanged.
- Edge cases:
  - T=0: oDone at cycle 2; no oClearAcc and no oFeedValid.
  - K=0: behaves as K=1, so one feed per tile.
- Configuration latching and start rules:
  - iPatternSel=9'o210 and iOutputShift=7 at start: outputs show these values from cycle 2 onward.
  - Changing the inputs mid-job does not change the outputs.
  - A second iStart while busy is ignored.
- Address wrap: ADDR_W=4, K=3, T=2.
  - oDataAddr runs 0..15, then 0,1.
- Reset mid-job: drop iRstN during the MAC phase of tile 1.
  - All outputs are 0 before the next clock edge; no oDone.
  - A fresh start after release runs normally.
